// File: rtl/rca_pkg.sv
// Shared types and helpers for the sequential ripple-carry adder/subtractor.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } rca_state_t;

  // Number of slice passes needed to cover an n-bit operand, chunk bits at a time.
  function automatic int steps(input int n, input int chunk);
    return n / chunk;
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry slice built from a chain of full adders.
// Exposes the carry into the MSB so the caller can derive signed overflow.
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co       = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/rca_seq_addsub.sv
// Multi-cycle N-bit adder/subtractor: one CHUNK-wide ripple slice is reused
// STEPS = N/CHUNK times, LSB chunk first, with the carry kept in a register.
// Subtraction is a + ~b + 1. Valid/ready handshake on both sides.
module rca_seq_addsub
  import rca_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         ovf,
  output logic         zero
);

  localparam int             STEPS = steps(N, CHUNK);
  localparam int             SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0]  LAST  = SW'(STEPS - 1);

  if (CHUNK < 1 || (N % CHUNK) != 0) begin : g_bad_params
    $fatal(1, "rca_seq_addsub: N (%0d) must be a multiple of CHUNK (%0d)", N, CHUNK);
  end

  rca_state_t       state, state_nx;
  logic [SW-1:0]    step;
  logic [N-1:0]     a_r, b_r, sum_r, sum_nx;
  logic             carry;
  logic             co_r, ovf_r, zero_r;

  logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
  logic             sl_co, sl_cmsb;

  rca_slice #(.W(CHUNK)) u_slice (
    .a        (sl_a),
    .b        (sl_b),
    .cin      (carry),
    .sum      (sl_sum),
    .co       (sl_co),
    .c_msb_in (sl_cmsb)
  );

  // Select the operand chunk addressed by step and merge the slice result back.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sl_a   = '0;
    sl_b   = '0;
    sum_nx = sum_r;
    for (int i = 0; i < STEPS; i++) begin
      if (step == SW'(i)) begin
        sl_a                      = a_r[i*CHUNK +: CHUNK];
        sl_b                      = b_r[i*CHUNK +: CHUNK];
        sum_nx[i*CHUNK +: CHUNK]  = sl_sum;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (step == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, per-chunk accumulation and final flag latching.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      co_r   <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            sum_r <= '0;
            step  <= '0;
          end
        end
        BUSY: begin
          sum_r <= sum_nx;
          carry <= sl_co;
          if (step == LAST) begin
            co_r   <= sl_co;
            ovf_r  <= sl_co ^ sl_cmsb;
            zero_r <= (sum_nx == '0);
          end else begin
            step <= step + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign co   = co_r;
  assign ovf  = ovf_r;
  assign zero = zero_r;

endmodule
